// File: rtl/seg7_bank.sv
// seg7_bank: NUM_DIGITS hex 7-segment bank with tear-free load, leading-zero blanking,
// per-digit enable and optional blinking (enabled by defining SEG7_BANK_BLINK_EN).
module seg7_bank #(
  parameter int NUM_DIGITS  = 6,
  parameter int TICK_DIV    = 12500000,
  parameter int BLINK_TICKS = 2
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    load_blank_lz,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic [4*NUM_DIGITS-1:0] shown_value,
  output logic                    tick
);

  localparam int            CW     = $clog2(TICK_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]           r_count;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_pend_value;
  logic                    r_pend_lz;
  logic [4*NUM_DIGITS-1:0] r_shown;
  logic                    r_shown_lz;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic                    w_tick;
  logic                    w_xfer;
  logic                    w_phase;
  logic [NUM_DIGITS-1:0]   w_blink;
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic [7*NUM_DIGITS-1:0] w_hex_next;

  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      4'hF:    g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign w_tick      = (r_count == C_LAST);
  assign w_xfer      = load_valid & ~r_pend_valid;
  assign load_ready  = ~r_pend_valid;
  assign tick        = w_tick;
  assign shown_value = r_shown;
  assign HEX         = r_hex;

  // Refresh prescaler, wraps at TICK_DIV-1
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  // Pending/shown word registers: shown only ever changes on a tick edge
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pend_valid <= 1'b0;
      r_pend_value <= '0;
      r_pend_lz    <= 1'b0;
      r_shown      <= '0;
      r_shown_lz   <= 1'b0;
    end else if (w_tick) begin
      if (r_pend_valid) begin
        r_shown      <= r_pend_value;
        r_shown_lz   <= r_pend_lz;
        r_pend_valid <= 1'b0;
      end else if (w_xfer) begin
        r_shown      <= load_value;
        r_shown_lz   <= load_blank_lz;
      end else begin
        r_shown      <= r_shown;
      end
    end else if (w_xfer) begin
      r_pend_valid <= 1'b1;
      r_pend_value <= load_value;
      r_pend_lz    <= load_blank_lz;
    end else begin
      r_pend_valid <= r_pend_valid;
    end
  end

`ifdef SEG7_BANK_BLINK_EN
  localparam int            BW       = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] C_BLAST  = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  // Blink phase toggles once every BLINK_TICKS ticks
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == C_BLAST) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end else begin
      r_phase <= r_phase;
    end
  end

  assign w_phase = r_phase;
`else
  assign w_phase = 1'b0;
`endif

  assign w_blink = blink_mask & {NUM_DIGITS{w_phase}};

  // Digit i is a leading zero when it and every digit above it is zero
  always_comb begin
    w_upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_upper_zero[i] = ((r_shown >> (4 * i)) == '0);
    end
  end

  // Per-digit blank priority: enable, then leading zero, then blink
  always_comb begin
    w_hex_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!digit_en[i]) begin
        w_hex_next[7*i +: 7] = 7'b1111111;
      end else if (r_shown_lz && (i != 0) && w_upper_zero[i]) begin
        w_hex_next[7*i +: 7] = 7'b1111111;
      end else if (w_blink[i]) begin
        w_hex_next[7*i +: 7] = 7'b1111111;
      end else begin
        w_hex_next[7*i +: 7] = seg_glyph(r_shown[4*i +: 4]);
      end
    end
  end

  // Registered segment outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_hex <= '1;
    end else begin
      r_hex <= w_hex_next;
    end
  end

endmodule

// File: tb/tb_seg7_bank.sv
// Self-checking bench for seg7_bank: transaction-level model compared every cycle,
// plus hand-computed literal expectations at key points.
`timescale 1ns/1ps
module tb_seg7_bank;
  localparam int ND = 6;
  localparam int TD = 4;
  localparam int BT = 2;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [23:0]   load_value = 24'h0;
  logic          load_blank_lz = 1'b0;
  logic [5:0]    digit_en = 6'h3F;
  logic [5:0]    blink_mask = 6'h00;
  logic [41:0]   HEX;
  logic [23:0]   shown_value;
  logic          tick;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  always #5 Clock = ~Clock;

  seg7_bank #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
    .Clock(Clock), .Resetn(Resetn), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_blank_lz(load_blank_lz), .digit_en(digit_en),
    .blink_mask(blink_mask), .HEX(HEX), .shown_value(shown_value), .tick(tick)
  );

  // Model state: pending words as a queue, tick count since reset, expected HEX
  logic [24:0] m_pend_q[$];
  logic [23:0] m_shown;
  logic        m_lz;
  int          m_count;
  int          m_ticks;
  logic [41:0] m_hex;

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] BL = 7'b1111111;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_phase();
`ifdef SEG7_BANK_BLINK_EN
    return ((m_ticks / BT) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [41:0] model_hex(input logic [23:0] v, input logic lz,
                                            input logic [5:0] en, input logic [5:0] mask,
                                            input logic ph);
    logic [41:0] h;
    for (int i = 0; i < ND; i++) begin
      if (!en[i])                                 h[7*i +: 7] = BL;
      else if (lz && i > 0 && (v >> (4*i)) == 0)  h[7*i +: 7] = BL;
      else if (ph && mask[i])                     h[7*i +: 7] = BL;
      else                                        h[7*i +: 7] = glyph[v[4*i +: 4]];
    end
    return h;
  endfunction

  task automatic model_reset();
    m_pend_q.delete();
    m_shown = 24'h0;
    m_lz    = 1'b0;
    m_count = 0;
    m_ticks = 0;
    m_hex   = '1;
  endtask

  task automatic model_edge();
    logic [41:0] h;
    logic [24:0] e;
    logic        t;
    h = model_hex(m_shown, m_lz, digit_en, blink_mask, model_phase());
    t = (m_count == TD - 1);
    if (load_valid && m_pend_q.size() == 0) m_pend_q.push_back({load_blank_lz, load_value});
    if (t) begin
      if (m_pend_q.size() > 0) begin
        e = m_pend_q.pop_front();
        m_lz    = e[24];
        m_shown = e[23:0];
      end
      m_ticks++;
    end
    m_count = (m_count + 1) % TD;
    m_hex   = h;
  endtask

  task automatic step();
    @(posedge Clock);
    if (Resetn) model_edge();
    else        model_reset();
    @(negedge Clock);
    #1;
  endtask

  task automatic wait_count(input int k);
    for (int n = 0; n < 2*TD && m_count != k; n++) step();
    if (m_count != k) begin
      checks++;
      errors++;
      $display("FAIL wait_count: count %0d never reached %0d", m_count, k);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge Clock) begin
    if (check_en) begin
      chk("hex", HEX, m_hex);
      chk("ready", load_ready, m_pend_q.size() == 0);
      chk("shown", shown_value, m_shown);
      chk("tick", tick, m_count == TD - 1);
    end
  end

  initial begin
    int blanks;
    model_reset();
    #2 Resetn = 1'b0;
    check_en = 1'b1;
    repeat (3) step();
    chk("reset_hex", HEX, 42'h3FF_FFFF_FFFF);
    chk("reset_ready", load_ready, 1'b1);
    chk("reset_shown", shown_value, 24'h0);
    Resetn = 1'b1;
    step();
    chk("release_hex", HEX, {6{7'b1000000}});

    // Load via pending register, commit on tick
    wait_count(0);
    load_value = 24'h00A3F1; load_blank_lz = 1'b1; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("pend_ready", load_ready, 1'b0);
    chk("pend_shown", shown_value, 24'h0);
    repeat (3) step();
    chk("commit_shown", shown_value, 24'h00A3F1);
    chk("commit_ready", load_ready, 1'b1);
    step();
    chk("commit_hex", HEX, {BL, BL, 7'b0001000, 7'b0110000, 7'b0001110, 7'b1111001});

    // Load in a tick cycle with nothing pending: immediate commit, ready stays high
    wait_count(3);
    load_value = 24'h123456; load_blank_lz = 1'b0; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("direct_shown", shown_value, 24'h123456);
    chk("direct_ready", load_ready, 1'b1);

    // Second word held while first is pending
    load_value = 24'h00BEEF; load_blank_lz = 1'b1; load_valid = 1'b1;
    step();
    load_value = 24'h0C0DE0; load_blank_lz = 1'b0;
    step();
    chk("hold_ready", load_ready, 1'b0);
    chk("hold_shown", shown_value, 24'h123456);
    step();
    step();
    chk("first_commit", shown_value, 24'h00BEEF);
    chk("first_ready", load_ready, 1'b1);
    step();
    load_valid = 1'b0;
    chk("second_pend", load_ready, 1'b0);
    repeat (3) step();
    chk("second_commit", shown_value, 24'h0C0DE0);
    step();

    // Per-digit enable
    digit_en = 6'b111011;
    step();
    chk("en_off_hex", HEX, {7'b1000000, 7'b1000110, 7'b1000000, BL, 7'b0000110, 7'b1000000});
    digit_en = 6'h3F;
    step();
    chk("en_on_d2", HEX[20:14], 7'b0100001);

    // Leading-zero boundaries
    wait_count(3);
    load_value = 24'h000000; load_blank_lz = 1'b1; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    chk("lz_zero_hex", HEX, {BL, BL, BL, BL, BL, 7'b1000000});
    wait_count(3);
    load_value = 24'h010000; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    chk("lz_inner_hex", HEX, {BL, 7'b1111001, {4{7'b1000000}}});

    // Blink on digit 0
    wait_count(3);
    load_value = 24'h000008; load_blank_lz = 1'b0; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    blink_mask = 6'b000001;
    blanks = 0;
    for (int n = 0; n < 24; n++) begin
      step();
      if (HEX[6:0] == BL) blanks++;
    end
`ifdef SEG7_BANK_BLINK_EN
    chk("blink_seen", (blanks > 4) && (blanks < 20), 1'b1);
`else
    chk("blink_steady", blanks, 0);
`endif
    blink_mask = 6'h00;

    // Reset while a word is pending
    wait_count(0);
    load_value = 24'h777777; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("pre_rst_ready", load_ready, 1'b0);
    Resetn = 1'b0;
    model_reset();
    step();
    chk("rst_hex", HEX, 42'h3FF_FFFF_FFFF);
    chk("rst_shown", shown_value, 24'h0);
    chk("rst_ready", load_ready, 1'b1);
    Resetn = 1'b1;
    repeat (6) step();
    chk("rst_no_commit", shown_value, 24'h0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
